pipeline_controller: RTL

Sequencing and hazard controller for the 5-stage MIPS pipeline. Owns the global stage enable (free-run / single-step / halted) and produces per-cycle PC-write, IF/ID-write, ID/EX bubble and IF/ID flush controls. Covers load-use stalls that the execute-stage forwarding unit cannot resolve, and branch-taken flushes. Sits beside the pipeline; driven by the debug unit and by the ID/EX, IF/ID and MEM/WB stage registers.

---
 rtl/pipeline_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_controller
// Description : Sequencing and hazard controller for the 5-stage MIPS
//               pipeline. Owns the global stage enable (free-run /
//               single-step / halted), and per cycle decides PC-write,
//               IF/ID-write, ID/EX bubble and IF/ID flush for load-use
//               stalls and taken-branch flushes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk            pipeline clock, all state updates on rising edge
//   i_reset          synchronous, active-high reset
//   i_run            pulse: start free-running execution (from IDLE)
//   i_step           pulse: execute exactly one pipeline cycle (from IDLE)
//   i_halt_wb        HALT instruction is in MEM/WB this cycle
//   i_memRead_ID_EX  instruction in ID/EX is a load
//   i_rt_ID_EX       load destination register in ID/EX
//   i_rs_IF_ID       rs of instruction in IF/ID
//   i_rt_IF_ID       rt of instruction in IF/ID
//   i_branch_taken   branch resolved taken (from EX/MEM)
//   o_enable         global stage-register enable
//   o_pc_write       PC update enable
//   o_if_id_write    IF/ID update enable
//   o_bubble         force ID/EX control signals to zero
//   o_flush_if_id    load NOP into IF/ID
//   o_cycle_count    enabled cycles since reset (saturating)
//   o_state          IDLE=00, RUN=01, STEP=10, DONE=11
//   o_done           high in DONE
// ============================================================================
module pipeline_controller #(
  parameter int N_BITS     = 32,
  parameter int N_BITS_REG = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_run,
  input  logic                  i_step,
  input  logic                  i_halt_wb,
  input  logic                  i_memRead_ID_EX,
  input  logic [N_BITS_REG-1:0] i_rt_ID_EX,
  input  logic [N_BITS_REG-1:0] i_rs_IF_ID,
  input  logic [N_BITS_REG-1:0] i_rt_IF_ID,
  input  logic                  i_branch_taken,
  output logic                  o_enable,
  output logic                  o_pc_write,
  output logic                  o_if_id_write,
  output logic                  o_bubble,
  output logic                  o_flush_if_id,
  output logic [N_BITS-1:0]     o_cycle_count,
  output logic [1:0]            o_state,
  output logic                  o_done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [N_BITS-1:0]   r_cycleCount;
  logic                w_enable;
  logic                w_loadUse;

  // Enable is decoded purely from the state register so that no input
  // combinationally reaches the stage-register enables.
  assign w_enable = (r_state == RUN) || (r_state == STEP);

  // Register 0 is hard-wired to zero in MIPS, so a load into $0 never
  // creates a real dependency.
  assign w_loadUse = i_memRead_ID_EX &&
                     (i_rt_ID_EX != '0) &&
                     ((i_rt_ID_EX == i_rs_IF_ID) || (i_rt_ID_EX == i_rt_IF_ID));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (i_run) begin
          w_nextState = RUN;
        end else if (i_step) begin
          w_nextState = STEP;
        end
      end
      RUN: begin
        if (i_halt_wb) begin
          w_nextState = DONE;
        end
      end
      STEP: begin
        // A step lasts exactly one cycle, but a HALT retiring in that
        // cycle still ends the program.
        w_nextState = i_halt_wb ? DONE : IDLE;
      end
      DONE: begin
        w_nextState = DONE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Hazard / flush controls. A taken branch wins over a load-use stall:
  // the instruction that would have stalled is on the wrong path anyway.
  always_comb begin
    o_pc_write    = 1'b0;
    o_if_id_write = 1'b0;
    o_bubble      = 1'b0;
    o_flush_if_id = 1'b0;
    if (w_enable) begin
      if (i_branch_taken) begin
        o_pc_write    = 1'b1;
        o_if_id_write = 1'b1;
        o_bubble      = 1'b1;
        o_flush_if_id = 1'b1;
      end else if (w_loadUse) begin
        o_bubble      = 1'b1;
      end else begin
        o_pc_write    = 1'b1;
        o_if_id_write = 1'b1;
      end
    end
  end

  // Enabled-cycle counter, saturating at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cycleCount <= '0;
    end else if (w_enable && (r_cycleCount != '1)) begin
      r_cycleCount <= r_cycleCount + 1'b1;
    end
  end

  assign o_enable      = w_enable;
  assign o_cycle_count = r_cycleCount;
  assign o_state       = r_state;
  assign o_done        = (r_state == DONE);

endmodule
`default_nettype wire
